// File: rtl/mac_sched_pkg.sv
// mac_sched_pkg: widths and operand/result types shared by the MAC scheduler and its pipeline
package mac_sched_pkg;
  import par_parameter::*;
  localparam int W = par + 1;
  localparam int RW = 2 * W;
  localparam int NREQ_DEF = 4;
  typedef logic [W-1:0] operand_t;
  typedef logic [RW-1:0] result_t;
endpackage

// File: rtl/par_parameter.sv
// par_parameter: project-wide base parameter; operand width is par+1
package par_parameter;
  localparam int par = 7;
endpackage

// File: rtl/mac_share_sched_mac_pipe.sv
// mac_pipe: 3-stage a*b+c with global enable adv, tag pass-through; ports clk,reset,adv,in_valid,in_id,a,b,c -> out_valid,out_id,out_data,busy
module mac_pipe
  import mac_sched_pkg::*;
#(
  parameter int IDW = 2
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           adv,
  input  logic           in_valid,
  input  logic [IDW-1:0] in_id,
  input  operand_t       a,
  input  operand_t       b,
  input  operand_t       c,
  output logic           out_valid,
  output logic [IDW-1:0] out_id,
  output result_t        out_data,
  output logic           busy
);
  logic [2:0] v_q, v_d;
  logic [2:0][IDW-1:0] id_q, id_d;
  operand_t a1_q, a1_d, b1_q, b1_d, c1_q, c1_d, c2_q, c2_d;
  result_t p2_q, p2_d, r3_q, r3_d;
  always_comb begin
    v_d  = adv ? {v_q[1:0], in_valid} : v_q;
    id_d = adv ? {id_q[1:0], in_id} : id_q;
    a1_d = adv ? a : a1_q;
    b1_d = adv ? b : b1_q;
    c1_d = adv ? c : c1_q;
    p2_d = adv ? RW'(a1_q) * RW'(b1_q) : p2_q;
    c2_d = adv ? c1_q : c2_q;
    r3_d = adv ? p2_q + RW'(c2_q) : r3_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      v_q  <= '0;
      id_q <= '0;
      a1_q <= '0;
      b1_q <= '0;
      c1_q <= '0;
      p2_q <= '0;
      c2_q <= '0;
      r3_q <= '0;
    end else begin
      v_q  <= v_d;
      id_q <= id_d;
      a1_q <= a1_d;
      b1_q <= b1_d;
      c1_q <= c1_d;
      p2_q <= p2_d;
      c2_q <= c2_d;
      r3_q <= r3_d;
    end
  end
  assign out_valid = v_q[2];
  assign out_id    = id_q[2];
  assign out_data  = r3_q;
  assign busy      = |v_q;
endmodule

// File: rtl/mac_share_sched.sv
// mac_share_sched: round-robin sharing of one 3-stage MAC among NREQ requesters; ports cfg_en/req_* in, req_ready out, res_* out with res_ready backpressure, busy
module mac_share_sched
  import mac_sched_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   cfg_en,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  input  logic [NREQ*W-1:0] req_c,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [IDW-1:0]    res_id,
  output result_t           res_data,
  output logic              busy
);
  logic [NREQ-1:0] cand;
  logic [IDW-1:0] ptr_q, ptr_d, gnt_id, idx;
  logic gnt_any, adv, fire;
  always_comb begin
    cand    = req_valid & cfg_en;
    adv     = !res_valid | res_ready;
    gnt_any = 1'b0;
    gnt_id  = '0;
    idx     = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx     = IDW'((int'(ptr_q) + k) % NREQ);
      gnt_id  = cand[idx] ? idx : gnt_id;
      gnt_any = gnt_any | cand[idx];
    end
    fire      = adv & gnt_any & !reset;
    req_ready = fire ? NREQ'(1) << gnt_id : '0;
    ptr_d     = fire ? IDW'((int'(gnt_id) + 1) % NREQ) : ptr_q;
  end
  always_ff @(posedge clk) ptr_q <= reset ? '0 : ptr_d;
  mac_pipe #(.IDW(IDW)) u_pipe (
    .clk      (clk),
    .reset    (reset),
    .adv      (adv),
    .in_valid (fire),
    .in_id    (gnt_id),
    .a        (req_a[gnt_id*W +: W]),
    .b        (req_b[gnt_id*W +: W]),
    .c        (req_c[gnt_id*W +: W]),
    .out_valid(res_valid),
    .out_id   (res_id),
    .out_data (res_data),
    .busy     (busy)
  );
endmodule

// File: tb/tb_mac_share_sched.sv
// tb_mac_share_sched: scoreboard bench for mac_share_sched with an independent round-robin/latency model
module tb_mac_share_sched;
  import mac_sched_pkg::*;
  localparam int NREQ = 4;
  localparam int IDW = 2;
  typedef struct packed {operand_t a; operand_t b; operand_t c;} op_t;
  typedef struct {logic [IDW-1:0] id; result_t data;} exp_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [NREQ-1:0] cfg_en = '1;
  logic [NREQ-1:0] req_valid = '0;
  logic [NREQ-1:0] req_ready;
  logic [NREQ*W-1:0] req_a = '0, req_b = '0, req_c = '0;
  logic res_valid;
  logic res_ready = 1'b1;
  logic [IDW-1:0] res_id;
  result_t res_data;
  logic busy;
  op_t src[NREQ][$];
  exp_t sb[$];
  int gnt_log[$];
  logic [2:0] mv = '0;
  int ptr = 0;
  int vectors = 0, miscompares = 0, accepted = 0;
  result_t last_data = '0;
  always #5 clk = ~clk;
  mac_share_sched #(.NREQ(NREQ)) dut (
    .clk(clk), .reset(reset), .cfg_en(cfg_en), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_c(req_c), .res_valid(res_valid), .res_ready(res_ready),
    .res_id(res_id), .res_data(res_data), .busy(busy)
  );
  task automatic drive_src();
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i] = src[i].size() > 0;
      req_a[i*W +: W] = req_valid[i] ? src[i][0].a : '0;
      req_b[i*W +: W] = req_valid[i] ? src[i][0].b : '0;
      req_c[i*W +: W] = req_valid[i] ? src[i][0].c : '0;
    end
  endtask
  task automatic step();
    logic [NREQ-1:0] exp_rdy;
    logic adv;
    int g;
    @(negedge clk);
    if (reset) begin
      mv = '0;
      ptr = 0;
      sb.delete();
    end else begin
      adv = !mv[2] || res_ready;
      g = -1;
      for (int k = 0; k < NREQ; k++) begin
        int i = (ptr + k) % NREQ;
        if (g < 0 && req_valid[i] && cfg_en[i]) g = i;
      end
      exp_rdy = '0;
      if (adv && g >= 0) exp_rdy[g] = 1'b1;
      vectors++;
      if (req_ready !== exp_rdy) begin
        miscompares++;
        $display("FAIL req_ready: got %b expected %b at %0t", req_ready, exp_rdy, $time);
      end
      vectors++;
      if (res_valid !== mv[2]) begin
        miscompares++;
        $display("FAIL res_valid: got %b expected %b at %0t", res_valid, mv[2], $time);
      end
      vectors++;
      if (busy !== |mv) begin
        miscompares++;
        $display("FAIL busy: got %b expected %b at %0t", busy, |mv, $time);
      end
      if (mv[2] && sb.size() > 0) begin
        vectors++;
        if (res_id !== sb[0].id || res_data !== sb[0].data) begin
          miscompares++;
          $display("FAIL result: got id %0d data %0d expected id %0d data %0d at %0t", res_id, res_data, sb[0].id, sb[0].data, $time);
        end
        if (res_ready) begin
          last_data = sb[0].data;
          accepted++;
          void'(sb.pop_front());
        end
      end
      if (adv) begin
        mv = {mv[1:0], g >= 0};
        if (g >= 0) begin
          sb.push_back('{id: IDW'(g), data: RW'(int'(src[g][0].a) * int'(src[g][0].b) + int'(src[g][0].c))});
          void'(src[g].pop_front());
          gnt_log.push_back(g);
          ptr = (g + 1) % NREQ;
        end
      end
    end
    @(posedge clk);
    #1;
    drive_src();
  endtask
  task automatic apply_reset();
    for (int i = 0; i < NREQ; i++) src[i].delete();
    drive_src();
    reset = 1'b1;
    step();
    reset = 1'b0;
    gnt_log.delete();
    accepted = 0;
  endtask
  task automatic drain();
    int n = 0;
    while ((src[0].size() + src[1].size() + src[2].size() + src[3].size() > 0 || mv != 0) && n < 200) begin
      step();
      n++;
    end
    vectors++;
    if (n >= 200) begin
      miscompares++;
      $display("FAIL drain timeout: got %0d cycles required < 200", n);
    end
  endtask
  task automatic check_int(string name, int got, int want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask
  task automatic test_reset();
    cfg_en = '1;
    res_ready = 1'b1;
    apply_reset();
    vectors++;
    if (res_valid !== 1'b0 || res_id !== '0 || res_data !== '0 || busy !== 1'b0 || req_ready !== '0) begin
      miscompares++;
      $display("FAIL reset outputs: got v%b id%0d d%0d busy%b rdy%b expected all zero", res_valid, res_id, res_data, busy, req_ready);
    end
    step();
  endtask
  task automatic test_single();
    apply_reset();
    src[0].push_back('{a: 8'd3, b: 8'd5, c: 8'd7});
    drive_src();
    drain();
    check_int("single data", int'(last_data), 22);
    check_int("single busy", int'(busy), 0);
  endtask
  task automatic test_contention();
    apply_reset();
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < NREQ; i++) src[i].push_back('{a: operand_t'(i + 1), b: 8'd2, c: 8'd0});
    drive_src();
    drain();
    for (int j = 0; j < 8; j++) check_int("contention grant", gnt_log[j], j % NREQ);
  endtask
  task automatic test_back_to_back_stall();
    apply_reset();
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < NREQ; i++) src[i].push_back('{a: operand_t'(i + 10 + r), b: operand_t'(i + 3), c: operand_t'(i)});
    drive_src();
    repeat (3) step();
    res_ready = 1'b0;
    repeat (4) step();
    res_ready = 1'b1;
    drain();
    check_int("backpressure accepted", accepted, 8);
  endtask
  task automatic test_max();
    apply_reset();
    src[2].push_back('{a: 8'hFF, b: 8'hFF, c: 8'hFF});
    drive_src();
    drain();
    check_int("max data", int'(last_data), 65280);
  endtask
  task automatic test_mask();
    apply_reset();
    cfg_en = 4'b1010;
    for (int r = 0; r < 3; r++)
      for (int i = 0; i < NREQ; i++) src[i].push_back('{a: operand_t'(i + r), b: 8'd7, c: operand_t'(r)});
    drive_src();
    repeat (4) step();
    cfg_en = 4'b1111;
    drain();
    check_int("mask grant0", gnt_log[0], 1);
    check_int("mask grant1", gnt_log[1], 3);
    check_int("mask grant2", gnt_log[2], 1);
    check_int("mask grant3", gnt_log[3], 3);
    check_int("mask reenable grant", gnt_log[4], 0);
  endtask
  task automatic test_reset_mid();
    apply_reset();
    src[1].push_back('{a: 8'd9, b: 8'd9, c: 8'd1});
    for (int r = 0; r < 2; r++) begin
      src[2].push_back('{a: operand_t'(20 + r), b: 8'd3, c: 8'd4});
      src[3].push_back('{a: operand_t'(30 + r), b: 8'd5, c: 8'd6});
    end
    drive_src();
    repeat (3) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    gnt_log.delete();
    check_int("reset_mid res_valid", int'(res_valid), 0);
    check_int("reset_mid busy", int'(busy), 0);
    drain();
    check_int("reset_mid first grant", gnt_log[0], 2);
  endtask
  initial begin
    drive_src();
    test_reset();
    test_single();
    test_contention();
    test_back_to_back_stall();
    test_max();
    test_mask();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/mac_share_sched.md
Name: mac_share_sched

Overview:
- Round-robin scheduler that shares one pipelined multiply-accumulate unit (res = a*b + c) between NREQ requesters.
- Each requester gets a valid/ready operand handshake. The scheduler tags every issued operation with its requester ID and returns results in issue order on a single result port with valid/ready backpressure.
- Sits between the operand-producing client blocks and the MAC datapath.

Parameters:
- NREQ, 4, number of requesters (2..8).
- W, par+1, operand width; par comes from package par_parameter.
- IDW, $clog2(NREQ), requester tag width.

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- cfg_en  in  NREQ  per-requester enable mask; 0 = never granted.
- req_valid  in  NREQ  requester i has operands ready.
- req_ready  out  NREQ  one-hot grant; transfer when req_valid[i] & req_ready[i].
- req_a  in  NREQ*W  packed operand A; slice i = [i*W +: W].
- req_b  in  NREQ*W  packed operand B.
- req_c  in  NREQ*W  packed addend C.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts result.
- res_id  out  IDW  requester that issued the result.
- res_data  out  2W  a*b + c.
- busy  out  1  any pipeline stage holds a valid operation.

Behaviour:
- Reset (synchronous, one edge): all stage valid bits cleared, RR pointer = 0. Outputs are then res_valid=0, res_id=0, res_data=0, busy=0, req_ready=0.
- Pipeline: three registered stages, each carrying a valid bit and the ID.
  - S1 captures a, b, c and the ID.
  - S2 holds the product a*b (2W) and c.
  - S3 holds the sum, zero-extending c to 2W. S3 drives the res_* outputs directly.
- Width rule: the maximum value (2^W-1)^2 + 2^W-1 < 2^(2W), so the sum never overflows. No truncation or saturation is needed.
- Advance: adv = !S3.valid | res_ready. All stages shift together when adv=1 and all stages hold when adv=0 (global stall). Bubbles are not squeezed.
- Arbitration:
  - Candidates: cand = req_valid & cfg_en.
  - Grant the first set bit of cand, searching from the pointer upward modulo NREQ.
  - req_ready is combinational: one-hot grant when adv=1, all-zero when adv=0 or cand=0.
  - After a grant to i, the pointer becomes (i+1) mod NREQ. With no grant, the pointer is unchanged.
- Latency: handshake in cycle k gives res_valid=1 in cycle k+3 when there are no stalls. Each adv=0 cycle adds one cycle.
- Throughput: one issue per cycle while res_ready stays high.
- Ordering: results leave in grant order. res_id/res_data stay stable while res_valid=1 and res_ready=0.
- res_valid deasserts after acceptance unless S2 holds a valid operation.
- Requester rule: once req_valid is raised it is held, with stable data, until its handshake. The scheduler does not check this.
- cfg_en change: takes effect for the next arbitration cycle. Operations already in flight complete normally.
- Reset mid-operation: in-flight operations are discarded. No stale result appears after reset is released.
- Simultaneous handshake and result acceptance in the same cycle is legal and keeps full throughput.
- busy = S1.valid | S2.valid | S3.valid.

Decomposition:
- Package mac_sched_pkg imports par_parameter and holds:
  - constants W = par+1, RW = 2*W, NREQ_DEF = 4;
  - typedefs operand_t (logic [W-1:0]) and result_t (logic [RW-1:0]).
- Sub-module mac_pipe:
  - 3-stage a*b+c with enable `adv`, valid bits and tag pass-through;
  - ports clk, reset, adv, in_valid, in_id, a, b, c, out_valid, out_id, out_data.
- The scheduler top holds the RR arbiter, adv logic and port packing.

Test Plan (bench uses par = 7, so W = 8, NREQ = 4):
1. Single op: req0 sends a=3, b=5, c=7 with res_ready=1 -> req_ready=0001 in the same cycle; res_valid=1 three cycles later with res_id=0, res_data=22; busy=0 afterwards.
2. Full contention: all four requesters hold req_valid with a=i+1, b=2, c=0 and cfg_en=1111 -> grants 0,1,2,3,0,...; results 2,4,6,8 with IDs 0,1,2,3 on consecutive cycles starting at cycle 3.
3. Backpressure: pipeline full, res_ready=0 for 4 cycles -> req_ready=0000 throughout; res_data held; no loss. After release, all results arrive in order with no duplicates.
4. Max values: a=b=c=255 -> res_data=65280 (0xFF00); no wrap.
5. Mask: cfg_en=1010 with all requesters valid -> grants alternate 1,3,1,3; req0 and req2 are never ready. Setting cfg_en=1111 mid-run -> the next grant follows the pointer.
6. Reset mid-run: three ops in flight, reset high for one cycle -> res_valid=0 and busy=0 the next cycle; no stale result afterwards; the first grant after reset goes to the lowest valid ID.
